// File: rtl/write_controller_pkg.sv
// Shared types for the UART register bridge: packet layout, write FSM states,
// destination constants and the saturating error-count helper.
package write_controller_pkg;

    localparam logic [7:0] WRITE_DEST_DEFAULT = 8'h01;
    localparam logic [7:0] READ_DEST_DEFAULT  = 8'h02;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic       Valid;
        logic [7:0] Data;
    } UART_PACKET;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        SEND_ACK,
        DISCARD
    } WRITE_STATE;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/write_controller_if.sv
// Bus bundle between the write controller (master) and the packet/register
// environment (slave): rx stream in, ack stream out, register write port out.
interface write_controller_if
    import write_controller_pkg::*;
#(
    parameter int DATA_LENGTH = 4
);
    UART_PACKET                 ipRxStream;
    logic                       ipTxReady;
    UART_PACKET                 opTxStream;
    logic [7:0]                 opWrAddress;
    logic [DATA_LENGTH*8-1:0]   opWrData;
    logic                       opWrEnable;
    logic [7:0]                 opErrorCount;

    modport master (
        input  ipRxStream,
        input  ipTxReady,
        output opTxStream,
        output opWrAddress,
        output opWrData,
        output opWrEnable,
        output opErrorCount
    );

    modport slave (
        output ipRxStream,
        output ipTxReady,
        input  opTxStream,
        input  opWrAddress,
        input  opWrData,
        input  opWrEnable,
        input  opErrorCount
    );
endinterface

// File: rtl/write_controller.sv
// Register-write endpoint: assembles address + big-endian word from write packets
// and strobes the register file. Define WRITE_CONTROLLER_ACK_EN for the ack packet.
module write_controller
    import write_controller_pkg::*;
#(
    parameter int         DATA_LENGTH = 4,
    parameter logic [7:0] WRITE_DEST  = WRITE_DEST_DEFAULT
) (
    input  logic              ipClk,
    input  logic              ipReset,
    write_controller_if.master bus
);

    localparam int W     = DATA_LENGTH * 8;
    localparam int CNT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_LENGTH - 1);

    UART_PACKET rx;
    assign rx = bus.ipRxStream;

    WRITE_STATE       state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [W-1:0]     wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       err_q, err_d;
    logic [1:0]       err_inc;
    logic             take_hdr;
    logic             dest_match, hdr_match, len_ok;
`ifdef WRITE_CONTROLLER_ACK_EN
    logic [7:0]       src_q, src_d;
    UART_PACKET       tx_q, tx_d;
`endif

    assign dest_match = (rx.Destination == WRITE_DEST);
    assign hdr_match  = rx.Valid && rx.SoP && dest_match;
    assign len_ok     = (rx.Length == 8'(DATA_LENGTH + 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        err_inc   = 2'd0;
        take_hdr  = 1'b0;
`ifdef WRITE_CONTROLLER_ACK_EN
        src_d     = src_q;
        tx_d      = tx_q;
`endif
        case (state_q)
            IDLE: take_hdr = hdr_match;
            GET_DATA: begin
                if (rx.Valid) begin
                    if (rx.SoP) begin
                        // A new start mid-packet kills the current one; a matching one restarts.
                        err_inc = 2'd1;
                        if (dest_match) take_hdr = 1'b1;
                        else            state_d  = rx.EoP ? IDLE : DISCARD;
                    end else begin
                        shift_d = {shift_q[W-9:0], rx.Data};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            if (rx.EoP) begin
                                state_d   = WRITE;
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = shift_d;
                            end else begin
                                err_inc = 2'd1;
                                state_d = DISCARD;
                            end
                        end else if (rx.EoP) begin
                            err_inc = 2'd1;
                            state_d = IDLE;
                        end
                    end
                end
            end
`ifdef WRITE_CONTROLLER_ACK_EN
            WRITE: begin
                state_d = SEND_ACK;
                tx_d    = '{Source: WRITE_DEST, Destination: src_q, Length: 8'd1,
                            SoP: 1'b1, EoP: 1'b1, Valid: 1'b1, Data: wr_addr_q};
                if (hdr_match) err_inc = 2'd1;
            end
            SEND_ACK: begin
                if (hdr_match) err_inc = 2'd1;
                if (bus.ipTxReady) begin
                    tx_d    = '0;
                    state_d = IDLE;
                end
            end
`else
            // With no ack to send, the strobe cycle doubles as IDLE so packets can abut.
            WRITE: begin
                state_d  = IDLE;
                take_hdr = hdr_match;
            end
`endif
            DISCARD: if (rx.Valid && rx.EoP) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (take_hdr) begin
            if (len_ok) begin
                addr_d  = rx.Data;
                cnt_d   = '0;
                state_d = GET_DATA;
`ifdef WRITE_CONTROLLER_ACK_EN
                src_d   = rx.Source;
`endif
            end else begin
                err_inc = err_inc + 2'd1;
                state_d = rx.EoP ? IDLE : DISCARD;
            end
        end

        err_d = sat_add(err_q, err_inc);
    end

    always_ff @(posedge ipClk) begin
        addr_q  <= addr_d;
        shift_q <= shift_d;
`ifdef WRITE_CONTROLLER_ACK_EN
        src_q   <= src_d;
`endif
        if (ipReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= '0;
`ifdef WRITE_CONTROLLER_ACK_EN
            tx_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
`ifdef WRITE_CONTROLLER_ACK_EN
            tx_q      <= tx_d;
`endif
        end
    end

    assign bus.opWrAddress  = wr_addr_q;
    assign bus.opWrData     = wr_data_q;
    assign bus.opWrEnable   = wr_en_q;
    assign bus.opErrorCount = err_q;
`ifdef WRITE_CONTROLLER_ACK_EN
    assign bus.opTxStream   = tx_q;
`else
    assign bus.opTxStream   = '0;
    logic unused_sink;
    assign unused_sink = ^{bus.ipTxReady, rx.Source};
`endif

endmodule

// File: tb/tb_write_controller.sv
// Scoreboard bench for write_controller: stimulus pushes expected writes, a
// negedge monitor pops and compares address, data and strobe cycle.
module tb_write_controller;
    import write_controller_pkg::*;

    logic ipClk = 1'b0;
    logic ipReset;
    always #5 ipClk = ~ipClk;

    write_controller_if #(.DATA_LENGTH(4)) bus();

    write_controller #(.DATA_LENGTH(4), .WRITE_DEST(8'h01)) dut (
        .ipClk  (ipClk),
        .ipReset(ipReset),
        .bus    (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge ipClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge ipClk) begin
        exp_t e;
        if (bus.opWrEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         bus.opWrAddress, bus.opWrData);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr",  64'(bus.opWrAddress), 64'(e.addr));
                check("wr_data",  64'(bus.opWrData),    64'(e.data));
                check("wr_cycle", 64'(cyc),             64'(e.at));
            end
        end
    end

    task automatic send_byte(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                             input logic sop, input logic eop, input logic [7:0] data);
        bus.ipRxStream = '{Source: src, Destination: dst, Length: len,
                           SoP: sop, EoP: eop, Valid: 1'b1, Data: data};
        @(posedge ipClk);
        #1;
        bus.ipRxStream = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ipClk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] src, input logic [7:0] addr,
                            input logic [31:0] word, input int gap);
        exp_t e;
        send_byte(src, 8'h01, 8'd5, 1'b1, 1'b0, addr);
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) idle(gap);
            send_byte(src, 8'h01, 8'd5, 1'b0, (i == 3), word[31-8*i -: 8]);
        end
        e.addr = addr;
        e.data = word;
        e.at   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic check_err(input string name, input logic [7:0] req);
        @(negedge ipClk);
        check(name, 64'(bus.opErrorCount), 64'(req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef WRITE_CONTROLLER_ACK_EN
        UART_PACKET exp_tx;
`endif
        bus.ipRxStream = '0;
        bus.ipTxReady  = 1'b1;
        ipReset        = 1'b1;
        repeat (3) @(posedge ipClk);
        #1;
        ipReset = 1'b0;

        @(negedge ipClk);
        check("rst_wr_en",   64'(bus.opWrEnable),   64'd0);
        check("rst_wr_addr", 64'(bus.opWrAddress),  64'd0);
        check("rst_wr_data", 64'(bus.opWrData),     64'd0);
        check("rst_err",     64'(bus.opErrorCount), 64'd0);
        check("rst_tx",      64'(bus.opTxStream),   64'd0);
        idle(1);

        // Plain write, then the same write with 3-cycle valid gaps
        send_pkt(8'h07, 8'h10, 32'hDEADBEEF, 0);
        idle(4);
        check_err("err_basic", 8'd0);
        send_pkt(8'h07, 8'h10, 32'hDEADBEEF, 3);
        idle(4);
        check_err("err_gap", 8'd0);

        // Bad length, then a good write
        send_byte(8'h07, 8'h01, 8'd3, 1'b1, 1'b0, 8'h55);
        send_byte(8'h07, 8'h01, 8'd3, 1'b0, 1'b0, 8'h11);
        send_byte(8'h07, 8'h01, 8'd3, 1'b0, 1'b1, 8'h22);
        send_pkt(8'h07, 8'h20, 32'h00000001, 0);
        idle(4);
        check_err("err_badlen", 8'd1);

        // SoP restart after two data bytes
        send_byte(8'h07, 8'h01, 8'd5, 1'b1, 1'b0, 8'h40);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'hAA);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'hBB);
        send_pkt(8'h07, 8'h30, 32'hCAFEF00D, 0);
        idle(4);
        check_err("err_restart", 8'd2);

        // Missing EoP on last byte, early EoP, foreign destination
        send_byte(8'h07, 8'h01, 8'd5, 1'b1, 1'b0, 8'h80);
        for (int i = 0; i < 4; i++) send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'h11);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b1, 8'h99);
        idle(2);
        check_err("err_noeop", 8'd3);
        send_byte(8'h07, 8'h01, 8'd5, 1'b1, 1'b0, 8'h81);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'h12);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b1, 8'h34);
        send_byte(8'h07, 8'h02, 8'd5, 1'b1, 1'b0, 8'h90);
        for (int i = 0; i < 4; i++) send_byte(8'h07, 8'h02, 8'd5, 1'b0, (i == 3), 8'h77);
        idle(4);
        check_err("err_early_foreign", 8'd4);

`ifdef WRITE_CONTROLLER_ACK_EN
        // Ack held while the transmitter is not ready
        bus.ipTxReady = 1'b0;
        send_pkt(8'h07, 8'h10, 32'h0BADF00D, 0);
        idle(1);
        exp_tx = '{Source: 8'h01, Destination: 8'h07, Length: 8'd1,
                   SoP: 1'b1, EoP: 1'b1, Valid: 1'b1, Data: 8'h10};
        for (int i = 0; i < 5; i++) begin
            @(negedge ipClk);
            check("ack_held", 64'(bus.opTxStream), 64'(exp_tx));
        end
        bus.ipTxReady = 1'b1;
        @(posedge ipClk);
        #1;
        bus.ipTxReady = 1'b0;
        @(negedge ipClk);
        check("ack_drop", 64'(bus.opTxStream.Valid), 64'd0);
        bus.ipTxReady = 1'b1;
        idle(2);
`else
        // Zero-gap back-to-back packets
        send_pkt(8'h07, 8'h70, 32'h01020304, 0);
        send_pkt(8'h07, 8'h71, 32'hA5A5A5A5, 0);
        idle(4);
        check_err("err_b2b", 8'd4);
`endif

        // Reset after the third data byte aborts the packet
        send_byte(8'h07, 8'h01, 8'd5, 1'b1, 1'b0, 8'h50);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'h11);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'h22);
        send_byte(8'h07, 8'h01, 8'd5, 1'b0, 1'b0, 8'h33);
        ipReset = 1'b1;
        @(posedge ipClk);
        #1;
        ipReset = 1'b0;
        @(negedge ipClk);
        check("mid_rst_wr_en",   64'(bus.opWrEnable),   64'd0);
        check("mid_rst_wr_addr", 64'(bus.opWrAddress),  64'd0);
        check("mid_rst_wr_data", 64'(bus.opWrData),     64'd0);
        check("mid_rst_err",     64'(bus.opErrorCount), 64'd0);
        check("mid_rst_tx",      64'(bus.opTxStream),   64'd0);
        idle(1);
        send_pkt(8'h07, 8'h60, 32'h12345678, 0);
        idle(4);
        check_err("err_after_rst", 8'd0);

        // 256 bad-length single-byte packets must saturate the error count
        for (int i = 0; i < 256; i++) send_byte(8'h07, 8'h01, 8'd1, 1'b1, 1'b1, 8'h00);
        idle(1);
        check_err("err_sat", 8'hFF);
        send_pkt(8'h07, 8'h61, 32'h89ABCDEF, 0);
        idle(4);
        check_err("err_sat_hold", 8'hFF);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge ipClk);
        @(negedge ipClk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
`ifndef WRITE_CONTROLLER_ACK_EN
        check("tx_idle", 64'(bus.opTxStream), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
